// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler
//   Sequences one multiply/divide at a time through the shared multi-cycle
//   unit, holds decode on register hazards against the in-flight result,
//   and merges the unit's result onto the single regfile write port.
//   The MW-stage pipeline write always wins the port; a result that
//   arrives while the port is taken is parked until the first free cycle.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   issue_valid/is_div/a/b/rd    mult/div issue from DX
//   issue_stall                  issue cannot be accepted this cycle
//   md_ctrl_mult, md_ctrl_div    one-cycle start pulses to the unit
//   md_a, md_b                   operands held for the unit
//   md_result/exception/ready    unit completion interface
//   fd_rs/rt/rd, fd_uses_rs/rt,  decode-stage register fields and
//   fd_writes_rd                 their valid qualifiers
//   hazard_stall                 freeze PC/FD, bubble DX
//   pipe_we/reg/data             MW-stage write request
//   wb_we/reg/data               regfile write port
//   busy                         an operation is in flight
module multdiv_scheduler #(
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic [4:0]  fd_rd,
  input  logic        fd_uses_rs,
  input  logic        fd_uses_rt,
  input  logic        fd_writes_rd,
  output logic        hazard_stall,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam logic [4:0]  RSTATUS  = 5'(RSTATUS_REG);
  localparam logic [31:0] MULT_EXC = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_EXC  = 32'(DIV_EXC_CODE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [4:0]  pend_rd;
  logic        pend_div;
  logic [31:0] hold_result;
  logic        hold_exc;

  // The exception target is only known at completion, so rstatus is
  // treated as a possible destination for every in-flight operation.
  // pend_rd of 0 never matches: r0 is never really written.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] prd);
    return ((prd != 5'd0) && (r == prd)) || (r == RSTATUS);
  endfunction

  // Result currently presented by the unit or parked in the hold register
  logic        res_exc;
  logic [31:0] res_val;
  logic        md_wr_slot;   // scheduler owns the port this cycle
  logic        md_we;
  logic [4:0]  md_reg;
  logic [31:0] md_data;

  always_comb begin
    res_exc = (state == HOLD) ? hold_exc    : md_exception;
    res_val = (state == HOLD) ? hold_result : md_result;
    md_wr_slot = !pipe_we &&
                 (((state == RUN) && md_ready) || (state == HOLD));
    if (res_exc) begin
      md_reg  = RSTATUS;
      md_data = pend_div ? DIV_EXC : MULT_EXC;
      md_we   = md_wr_slot;
    end else begin
      md_reg  = pend_rd;
      md_data = res_val;
      md_we   = md_wr_slot && (pend_rd != 5'd0);
    end
  end

  // Write-port merge: pipeline has priority
  always_comb begin
    wb_we   = pipe_we;
    wb_reg  = pipe_reg;
    wb_data = pipe_data;
    if (!pipe_we && md_we) begin
      wb_we   = 1'b1;
      wb_reg  = md_reg;
      wb_data = md_data;
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    issue_stall  = issue_valid && busy;
    md_ctrl_mult = (state == START) && !pend_div;
    md_ctrl_div  = (state == START) &&  pend_div;
    hazard_stall = busy && (
                   (fd_uses_rs   && reg_match(fd_rs, pend_rd)) ||
                   (fd_uses_rt   && reg_match(fd_rt, pend_rd)) ||
                   (fd_writes_rd && reg_match(fd_rd, pend_rd)));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (issue_valid) state_next = START;
      START: state_next = RUN;
      RUN:   if (md_ready) state_next = pipe_we ? HOLD : IDLE;
      HOLD:  if (!pipe_we) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and operand/result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      md_a        <= 32'd0;
      md_b        <= 32'd0;
      pend_rd     <= 5'd0;
      pend_div    <= 1'b0;
      hold_result <= 32'd0;
      hold_exc    <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && issue_valid) begin
        md_a     <= issue_a;
        md_b     <= issue_b;
        pend_rd  <= issue_rd;
        pend_div <= issue_is_div;
      end
      if ((state == RUN) && md_ready && pipe_we) begin
        hold_result <= md_result;
        hold_exc    <= md_exception;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed testbench for multdiv_scheduler. Inputs change 1ns after the
// rising edge; combinational outputs are sampled 1ns later.
module tb_multdiv_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_div;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        issue_stall, md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_a, md_b, md_result;
  logic        md_exception, md_ready;
  logic [4:0]  fd_rs, fd_rt, fd_rd;
  logic        fd_uses_rs, fd_uses_rt, fd_writes_rd;
  logic        hazard_stall;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_writes_rd(fd_writes_rd),
    .hazard_stall(hazard_stall),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic is_div, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_a      = a;
    issue_b      = b;
    issue_rd     = rd;
  endtask

  task automatic fd_clear();
    fd_uses_rs = 0; fd_uses_rt = 0; fd_writes_rd = 0;
    fd_rs = 0; fd_rt = 0; fd_rd = 0;
  endtask

  initial begin
    reset = 1; issue_valid = 0; issue_is_div = 0;
    issue_a = 0; issue_b = 0; issue_rd = 0;
    md_result = 0; md_exception = 0; md_ready = 0;
    pipe_we = 0; pipe_reg = 0; pipe_data = 0;
    fd_clear();
    tick(); tick();

    // reset state, still in reset
    pipe_we = 1; pipe_reg = 3; pipe_data = 77;
    fd_uses_rs = 1; fd_rs = 30;
    settle();
    check("rst_busy", busy, 0);
    check("rst_issue_stall", issue_stall, 0);
    check("rst_hazard", hazard_stall, 0);
    check("rst_mult", md_ctrl_mult, 0);
    check("rst_div", md_ctrl_div, 0);
    check("rst_md_a", md_a, 0);
    check("rst_md_b", md_b, 0);
    check("rst_wb_we", wb_we, 1);
    check("rst_wb_reg", wb_reg, 3);
    check("rst_wb_data", wb_data, 77);
    pipe_we = 0; pipe_reg = 0; pipe_data = 0;
    fd_clear();
    reset = 0;
    tick();

    // mult 6*7 -> r5
    issue(0, 6, 7, 5);
    tick();                      // edge N: accepted
    issue_valid = 0;
    check("m1_start_mult", md_ctrl_mult, 1);
    check("m1_start_div", md_ctrl_div, 0);
    check("m1_busy", busy, 1);
    check("m1_md_a", md_a, 6);
    check("m1_md_b", md_b, 7);
    tick();                      // RUN
    check("m1_run_mult", md_ctrl_mult, 0);
    check("m1_run_md_a", md_a, 6);
    // hazards against pend_rd=5
    fd_uses_rs = 1; fd_rs = 5; settle();
    check("hz_rs5", hazard_stall, 1);
    fd_clear(); fd_uses_rt = 1; fd_rt = 30; settle();
    check("hz_rt30", hazard_stall, 1);
    fd_clear(); fd_writes_rd = 1; fd_rd = 5; settle();
    check("hz_rd5", hazard_stall, 1);
    fd_clear(); fd_uses_rs = 1; fd_rs = 6; settle();
    check("hz_rs6", hazard_stall, 0);
    fd_clear();
    for (int i = 0; i < 14; i++) tick();
    md_ready = 1; md_result = 42; settle();
    check("m1_wb_we", wb_we, 1);
    check("m1_wb_reg", wb_reg, 5);
    check("m1_wb_data", wb_data, 42);
    check("m1_busy_wr", busy, 1);
    tick();
    md_ready = 0; md_result = 0; settle();
    check("m1_busy_after", busy, 0);
    check("m1_wb_idle", wb_we, 0);

    // div completes while pipeline holds the port for 3 cycles
    issue(1, 100, 7, 9);
    tick();
    issue_valid = 0;
    check("d1_start_div", md_ctrl_div, 1);
    check("d1_start_mult", md_ctrl_mult, 0);
    tick(); tick(); tick();
    md_ready = 1; md_result = 14; pipe_we = 1; pipe_reg = 8; pipe_data = 9;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("d1_pipe_we", wb_we, 1);
      check("d1_pipe_reg", wb_reg, 8);
      check("d1_pipe_data", wb_data, 9);
      tick();
      md_ready = 0; md_result = 32'hdead;
    end
    pipe_we = 0; pipe_reg = 0; pipe_data = 0; settle();
    check("d1_wb_we", wb_we, 1);
    check("d1_wb_reg", wb_reg, 9);
    check("d1_wb_data", wb_data, 14);
    tick();
    check("d1_busy_after", busy, 0);
    check("d1_wb_idle", wb_we, 0);

    // mult exception, rd=12
    issue(0, 32'h7fffffff, 2, 12);
    tick(); issue_valid = 0;
    tick(); tick();
    md_ready = 1; md_exception = 1; md_result = 123; settle();
    check("mx_wb_we", wb_we, 1);
    check("mx_wb_reg", wb_reg, 30);
    check("mx_wb_data", wb_data, 4);
    tick();
    md_ready = 0; md_exception = 0; settle();
    check("mx_wb_idle", wb_we, 0);

    // div exception, rd=12
    issue(1, 5, 0, 12);
    tick(); issue_valid = 0;
    tick(); tick();
    md_ready = 1; md_exception = 1; settle();
    check("dx_wb_reg", wb_reg, 30);
    check("dx_wb_data", wb_data, 5);
    tick();
    md_ready = 0; md_exception = 0;

    // pend_rd = 0: no hazard on r0, no write
    issue(0, 3, 3, 0);
    tick(); issue_valid = 0;
    tick();
    fd_uses_rs = 1; fd_rs = 0; settle();
    check("r0_hazard", hazard_stall, 0);
    fd_clear();
    md_ready = 1; md_result = 9; settle();
    check("r0_wb_we", wb_we, 0);
    tick();
    md_ready = 0; settle();
    check("r0_busy_after", busy, 0);

    // second issue while busy, then reset during RUN
    issue(0, 2, 3, 7);
    tick();
    issue(0, 1, 2, 3);           // held in DX
    settle();
    check("b2b_stall_start", issue_stall, 1);
    tick();                      // RUN
    check("b2b_stall_run", issue_stall, 1);
    md_ready = 1; md_result = 6; settle();
    check("b2b_wb_reg", wb_reg, 7);
    check("b2b_wb_data", wb_data, 6);
    tick();                      // IDLE
    md_ready = 0; settle();
    check("b2b_stall_idle", issue_stall, 0);
    tick();                      // second issue accepted
    issue_valid = 0;
    check("b2b_start", md_ctrl_mult, 1);
    check("b2b_md_a", md_a, 1);
    check("b2b_md_b", md_b, 2);
    tick();                      // RUN
    reset = 1;
    tick();
    reset = 0;
    check("rstrun_busy", busy, 0);
    check("rstrun_md_a", md_a, 0);
    md_ready = 1; md_result = 99; settle();
    check("rstrun_wb_we", wb_we, 0);
    tick();
    md_ready = 0; settle();
    check("rstrun_busy2", busy, 0);
    check("rstrun_mult", md_ctrl_mult, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Sequencing and write-port arbitration controller for the shared multi-cycle multiply/divide unit of the 5-stage pipeline. Accepts one mult/div issue from the DX stage and pulses the unit's start controls. Tracks the in-flight destination register so decode can be held on hazards. Merges the unit's result onto the single regfile write port alongside normal MW-stage writeback, buffering the result when the port is busy.

## Interface
Parameters:
- RSTATUS_REG, 30, register written on multdiv exception
- MULT_EXC_CODE, 4, rstatus value for mult overflow
- DIV_EXC_CODE, 5, rstatus value for divide exception

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- issue_valid  in  1  DX stage holds a mult or div
- issue_is_div  in  1  1 = div, 0 = mult (sampled with issue_valid)
- issue_a, issue_b  in  32  bypassed operands
- issue_rd  in  5  destination register
- issue_stall  out  1  issue cannot be accepted this cycle
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses to the unit
- md_a, md_b  out  32  held operands to the unit
- md_result  in  32  unit result
- md_exception  in  1  unit exception, valid with md_ready
- md_ready  in  1  unit result valid (one cycle)
- fd_rs, fd_rt, fd_rd  in  5  decode-stage register fields
- fd_uses_rs, fd_uses_rt, fd_writes_rd  in  1  field-valid qualifiers
- hazard_stall  out  1  freeze PC/FD, bubble DX
- pipe_we  in  1  MW-stage write request
- pipe_reg  in  5  MW-stage destination
- pipe_data  in  32  MW-stage write data
- wb_we  out  1  regfile write enable
- wb_reg  out  5  regfile write register
- wb_data  out  32  regfile write data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, RUN, HOLD.
- IDLE: on issue_valid, latch issue_a/b into md_a/b, issue_rd into pend_rd, issue_is_div into pend_div. Go to START.
- START: assert exactly one of md_ctrl_mult/md_ctrl_div for this single cycle. Go to RUN.
- RUN: wait for md_ready.
  - md_ready with pipe_we=0: write the result this cycle, then go to IDLE.
  - md_ready with pipe_we=1: capture md_result/md_exception into a hold register, go to HOLD.
- HOLD: write the held value on the first cycle with pipe_we=0, then go to IDLE.
- Result write:
  - No exception: wb_reg=pend_rd, wb_data=result.
  - Exception: wb_reg=RSTATUS_REG, wb_data=DIV_EXC_CODE if pend_div else MULT_EXC_CODE.
  - Non-exception result with pend_rd=0: complete the operation but keep wb_we=0.
- Port arbitration:
  - The pipeline always has priority. When pipe_we=1, wb_* = pipe_*.
  - wb_we = pipe_we | multdiv write. The two never drive the port in the same cycle.
- issue_stall = issue_valid & (state != IDLE).
- hazard_stall = busy & any of:
  - fd_uses_rs & fd_rs matches
  - fd_uses_rt & fd_rt matches
  - fd_writes_rd & fd_rd matches (WAW)
  - "match" means equal to pend_rd (when pend_rd != 0) or equal to RSTATUS_REG (exception target unknown until completion).
- Outputs are combinational from state/registers. md_a/md_b stay stable from START until return to IDLE.
- Ignore md_ready outside RUN. Ignore issue_valid outside IDLE.

## Timing
- Reset values:
  - state=IDLE; busy=0; issue_stall=0; hazard_stall=0.
  - md_ctrl_mult=md_ctrl_div=0; md_a=md_b=0.
  - pend_rd=0 and the hold register=0.
  - wb_* reflect pipe_* only.
- Issue accepted at edge N. Start pulse is high in cycle N+1. busy is high from N+1 until the cycle after the write.
- The write occurs in the same cycle md_ready is seen if the port is free. Otherwise it occurs in the first later cycle with pipe_we=0.
- Back-to-back: a new issue is accepted the cycle after the write (IDLE). issue_stall covers the gap.
- Reset mid-operation (any state): return to IDLE next edge, drop the pending/held result, no write. The unit is restarted only by a later start pulse.
- reset has priority over every other input on the same edge.

## Test plan
- Mult issue, a=6, b=7, rd=5; md_ready 16 cycles later with pipe_we=0 -> single md_ctrl_mult pulse in cycle N+1; wb_we=1, wb_reg=5, wb_data=42 in the md_ready cycle; busy drops next cycle.
- Div completes while pipe_we=1 for 3 cycles (pipe_reg=8, pipe_data=9) -> pipeline writes are passed through unchanged; the div result is written on the 4th cycle; no cycle has two writers.
- Mult with md_exception=1, rd=12 -> wb_reg=30, wb_data=4; register 12 is not written. Repeat for div -> wb_data=5.
- While busy with pend_rd=5, decode presents fd_rs=5, then fd_rt=30, then fd_rd=5, then fd_rs=6 -> hazard_stall is 1, 1, 1, 0 respectively; with pend_rd=0 and fd_rs=0 -> hazard_stall=0.
- Second issue_valid during RUN -> issue_stall=1 until IDLE, then accepted; reset asserted in RUN -> IDLE next cycle, no wb_we from multdiv even if md_ready follows.
